// File: rtl/strip_loader_if.sv
// Pixel stream into the loader and the column-step bus out to the edge-detection core.
interface strip_loader_if #(
  parameter int PW = 5
);
  logic          in_valid;
  logic [PW-1:0] in_pixel;
  logic          in_ready;
  logic          chip_start;
  logic          out_valid;
  logic          load_end;
  logic [PW-1:0] pixel_out0;
  logic [PW-1:0] pixel_out1;
  logic [PW-1:0] pixel_out2;
  logic [PW-1:0] pixel_out3;
  logic [PW-1:0] pixel_out4;

  modport master (
    output in_valid, in_pixel,
    input  in_ready, chip_start, out_valid, load_end,
    input  pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4
  );

  modport slave (
    input  in_valid, in_pixel,
    output in_ready, chip_start, out_valid, load_end,
    output pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4
  );
endinterface

// File: rtl/strip_loader.sv
// Buffers one raster frame, then replays it gap-free as column steps of STRIP rows.
// chip_start one cycle after the last accepted pixel, then one step per cycle; in_ready low while replaying.
module strip_loader #(
  parameter int IMG_W = 20,
  parameter int IMG_H = 20,
  parameter int STRIP = 5,
  parameter int PW    = 5
) (
  input logic          clk,
  input logic          reset,
  strip_loader_if.slave bus
);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NGRP  = IMG_H / STRIP;
  localparam int NSTEP = NGRP * IMG_W;
  localparam int AW    = $clog2(NPIX);
  localparam int SW    = $clog2(NSTEP);
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {FILL, START, EMIT} state_t;

  state_t        state;
  logic [AW-1:0] wr;
  logic [SW-1:0] s;
  logic [CW-1:0] col;
  logic [GW-1:0] grp;

  logic [PW-1:0] mem [NPIX];
  logic [CW-1:0] nxt_col;
  logic [GW-1:0] nxt_grp;
  logic [PW-1:0] rd_pix [STRIP];
  logic          wr_en;

  assign wr_en = reset && (state == FILL) && bus.in_ready && bus.in_valid;

  // Frame storage carries no reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr] <= bus.in_pixel;
  end

  // Address the step about to be loaded so the output registers always hold the current column.
  always_comb begin
    nxt_col = '0;
    nxt_grp = '0;
    if (state == EMIT) begin
      if (col == CW'(IMG_W - 1)) begin
        nxt_grp = grp + GW'(1);
      end else begin
        nxt_col = col + CW'(1);
        nxt_grp = grp;
      end
    end
    for (int k = 0; k < STRIP; k++) begin
      rd_pix[k] = mem[AW'((int'(nxt_grp) * STRIP + k) * IMG_W + int'(nxt_col))];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= FILL;
      wr             <= '0;
      s              <= '0;
      col            <= '0;
      grp            <= '0;
      bus.in_ready   <= 1'b0;
      bus.chip_start <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.load_end   <= 1'b0;
      bus.pixel_out0 <= '0;
      bus.pixel_out1 <= '0;
      bus.pixel_out2 <= '0;
      bus.pixel_out3 <= '0;
      bus.pixel_out4 <= '0;
    end else begin
      case (state)
        FILL: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            if (wr == AW'(NPIX - 1)) begin
              state          <= START;
              bus.in_ready   <= 1'b0;
              bus.chip_start <= 1'b1;
            end else begin
              wr <= wr + AW'(1);
            end
          end
        end
        START: begin
          bus.chip_start <= 1'b0;
          bus.out_valid  <= 1'b1;
          bus.load_end   <= (NSTEP == 1);
          bus.pixel_out0 <= rd_pix[0];
          bus.pixel_out1 <= rd_pix[1];
          bus.pixel_out2 <= rd_pix[2];
          bus.pixel_out3 <= rd_pix[3];
          bus.pixel_out4 <= rd_pix[4];
          s              <= '0;
          col            <= nxt_col;
          grp            <= nxt_grp;
          state          <= EMIT;
        end
        EMIT: begin
          if (s == SW'(NSTEP - 1)) begin
            bus.out_valid  <= 1'b0;
            bus.load_end   <= 1'b0;
            bus.pixel_out0 <= '0;
            bus.pixel_out1 <= '0;
            bus.pixel_out2 <= '0;
            bus.pixel_out3 <= '0;
            bus.pixel_out4 <= '0;
            bus.in_ready   <= 1'b1;
            wr             <= '0;
            s              <= '0;
            col            <= '0;
            grp            <= '0;
            state          <= FILL;
          end else begin
            bus.load_end   <= (s == SW'(NSTEP - 2));
            bus.pixel_out0 <= rd_pix[0];
            bus.pixel_out1 <= rd_pix[1];
            bus.pixel_out2 <= rd_pix[2];
            bus.pixel_out3 <= rd_pix[3];
            bus.pixel_out4 <= rd_pix[4];
            s              <= s + SW'(1);
            col            <= nxt_col;
            grp            <= nxt_grp;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
